rr_channel_merge: RTL
=====================

Name: rr_channel_merge

Overview:
- Merges N_CH independent valid/ready input channels of WIDTH-bit data into one registered output stream.
- Successor to the fixed three-port 32-bit sink module, now parametrised in channel count and width.
- Adds arbitration (round-robin or fixed priority), backpressure, and a source-index tag.
- Sits between per-lane producers (e.g. instance arrays of interfaces) and a single downstream consumer.

Parameters:
- N_CH, 4, number of input channels (>=1)
- WIDTH, 32, data bits per channel (>=1)
- MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins)
- IDX_W, $clog2(N_CH) (minimum 1), width of the source index

Ports:
- i_clk  input  1  clock; all logic on rising edge
- i_rst  input  1  reset, asynchronous, active-low
- i_valid  input  N_CH  per-channel valid
- i_data  input  N_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- o_ready  output  N_CH  per-channel ready (combinational)
- o_valid  output  1  output valid (registered)
- o_data  output  WIDTH  output data (registered)
- o_src  output  IDX_W  channel index of o_data (registered)
- i_ready  input  1  downstream ready

Behaviour:
- Reset (i_rst=0, asynchronous):
  - o_valid=0, o_data=0, o_src=0.
  - Round-robin pointer ptr=0.
  - Reset asserted mid-transfer discards the held beat; no beat is emitted after release until a new input handshake.
- Load condition: load = !o_valid || i_ready, i.e. the output stage is empty or is draining this cycle.
- Grant (combinational, one-hot or zero):
  - MODE=0: the first k with i_valid[k]=1, searching ptr, ptr+1, …, N_CH-1, 0, …, ptr-1.
  - MODE=1: the lowest k with i_valid[k]=1.
  - No valid input: grant=0.
- o_ready[k] = load && grant[k]. At most one o_ready bit is high per cycle. o_ready must not depend on i_valid of the same channel except through grant.
- Input handshake on channel k: i_valid[k] && o_ready[k]. On the next edge:
  - o_data <= channel k data
  - o_src <= k
  - o_valid <= 1
- Output handshake: o_valid && i_ready. If no input handshake occurs in the same cycle, o_valid <= 0 at the next edge. o_data/o_src keep their value.
- Simultaneous output and input handshake: the new beat replaces the old one with no bubble. Full throughput is 1 beat/cycle.
- Stall (o_valid && !i_ready): o_valid, o_data and o_src hold stable, and all o_ready are 0.
- Latency: 1 cycle from input handshake to o_valid.
- Pointer (MODE=0):
  - On an input handshake from channel k, ptr <= (k+1) mod N_CH.
  - Wrap: k=N_CH-1 sets ptr to 0.
  - ptr is unchanged otherwise. In MODE=1, ptr is unused and held at 0.
- N_CH=1: grant[0]=i_valid[0] and o_src is constant 0.
- Inputs follow valid/ready rules: a producer keeps data stable while valid and not ready. The block does not rely on this for correctness.
- No combinational path from i_ready to o_valid/o_data/o_src. The only comb path from i_ready goes to o_ready.

Test Plan:
- Reset release with i_valid=0: o_valid=0, o_data=0, o_src=0, o_ready=0000. Assert i_rst=0 while o_valid=1 → o_valid=0 immediately, ptr=0.
- N_CH=4, MODE=0, i_ready=1, i_valid=1111 held, data[k]=0xA0+k: o_src sequence 0,1,2,3,0,1 on consecutive cycles, with o_valid continuously 1.
- MODE=0, i_valid=0101, i_ready=1: grants alternate 0,2,0,2. Then drop to i_valid=0100 after a channel-2 grant (ptr=3) → channel 2 is granted next, wrapping through 3 and 0.
- MODE=1, i_valid=1110, i_ready=1: o_src=1 every cycle. Channels 2 and 3 are never granted while channel 1 stays valid.
- Backpressure: beat from channel 3 (data 0xDEADBEEF) held with i_ready=0 for 5 cycles → o_valid=1, o_data=0xDEADBEEF, o_src=3 stable and o_ready=0000 throughout. Raising i_ready gives the next beat on the following edge with no bubble.
- N_CH=1, WIDTH=8: single-channel pass-through at 1 beat/cycle with 1-cycle latency, and o_src=0 always.

Source files
------------

// File: rtl/rr_channel_merge.sv
// rr_channel_merge
//   Merges N_CH valid/ready input channels of WIDTH-bit data into a single
//   registered output stream. The winning channel is chosen either
//   round-robin (MODE=0) or by fixed priority, lowest index first (MODE=1).
//   Each output beat carries the index of the channel it came from.
//
// Ports
//   i_clk    clock, rising edge
//   i_rst    asynchronous active-low reset
//   i_valid  per-channel valid
//   i_data   channel k at bits [k*WIDTH +: WIDTH]
//   o_ready  per-channel ready (combinational, at most one bit high)
//   o_valid  output beat valid (registered)
//   o_data   output beat data (registered)
//   o_src    channel index of o_data (registered)
//   i_ready  downstream ready

module rr_channel_merge #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned MODE  = 0,
    parameter int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [N_CH-1:0]       i_valid,
    input  logic [N_CH*WIDTH-1:0] i_data,
    output logic [N_CH-1:0]       o_ready,
    output logic                  o_valid,
    output logic [WIDTH-1:0]      o_data,
    output logic [IDX_W-1:0]      o_src,
    input  logic                  i_ready
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [IDX_W-1:0] src_q, src_d;

    logic [N_CH-1:0]  grant;
    logic             found;
    logic [IDX_W-1:0] gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic             load;
    logic             in_hs;
    int unsigned      base;
    int unsigned      cand;

    // Channel visited at step 'off' of a search starting at 'start', wrapping at N_CH.
    function automatic int unsigned search_idx(int unsigned start, int unsigned off);
        int unsigned s;
        s = start + off;
        if (s >= N_CH) begin
            s = s - N_CH;
        end
        return s;
    endfunction

    // Fixed priority is a round-robin search that always starts at channel 0.
    always_comb begin
        grant    = '0;
        found    = 1'b0;
        gnt_idx  = '0;
        gnt_data = '0;
        cand     = 0;
        base     = (MODE == 0) ? 32'(ptr_q) : 0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            cand = search_idx(base, i);
            if (!found && i_valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                gnt_idx     = IDX_W'(cand);
                gnt_data    = i_data[cand*WIDTH +: WIDTH];
            end
        end
    end

    // The output register can accept a beat when empty or draining this cycle.
    assign load    = !valid_q || i_ready;
    assign o_ready = load ? grant : '0;
    assign in_hs   = load && found;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        src_d   = src_q;
        ptr_d   = ptr_q;
        if (in_hs) begin
            valid_d = 1'b1;
            data_d  = gnt_data;
            src_d   = gnt_idx;
            if (MODE == 0) begin
                ptr_d = (32'(gnt_idx) == N_CH - 1) ? '0 : gnt_idx + 1'b1;
            end
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            ptr_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            src_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            src_q   <= src_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_src   = src_q;

endmodule
